// File: rtl/force_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : force_wb_arbiter
// Description : Shares one force-writeback bus between NUM_PORTS force
//               distributors. Each port pushes into its own FIFO; a
//               round-robin scheduler drains the FIFOs into a registered
//               valid/ready output. Also collects the per-port "all reference
//               writebacks issued" pulses and reports when the writeback phase
//               has fully drained.
// Ports       : clk, rst           clock, synchronous active-high reset
//               in_data/in_valid   per-port writeback push (never stalls)
//               in_ready           per-port "bus ready" hint to distributor
//               in_ref_done        per-port all_ref_wb_issued pulse
//               out_data/out_port  granted word and its source port
//               out_valid/out_ready registered output handshake
//               phase_done         1-cycle pulse: writeback phase drained
//               overflow           sticky per-port FIFO overflow flags
// Revision    : 1.0  initial release
// ============================================================================
module force_wb_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int WB_WIDTH   = 112,
  parameter int FIFO_DEPTH = 8,
  parameter int SKID       = 2,
  parameter int PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*WB_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS-1:0]          in_ref_done,
  output logic [WB_WIDTH-1:0]           out_data,
  output logic [PORT_W-1:0]             out_port,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          phase_done,
  output logic [NUM_PORTS-1:0]          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  c_full      = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  c_ready_max = CNT_W'(FIFO_DEPTH - SKID);
  localparam logic [PORT_W-1:0] c_last_port = PORT_W'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  // Per-port FIFO storage and bookkeeping
  logic [WB_WIDTH-1:0] r_mem   [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr  [NUM_PORTS];
  logic [PTR_W-1:0]    r_rptr  [NUM_PORTS];
  logic [CNT_W-1:0]    r_count [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_overflow;

  // Output register and scheduler state
  logic [WB_WIDTH-1:0] r_out_data;
  logic [PORT_W-1:0]   r_out_port;
  logic                r_out_valid;
  logic [PORT_W-1:0]   r_rr_ptr;

  // Done tracking
  logic [NUM_PORTS-1:0] r_done_lat;
  state_t               r_state;
  state_t               w_state_next;

  logic [NUM_PORTS-1:0] w_nonempty;
  logic [NUM_PORTS-1:0] w_in_ready;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_push;
  logic [PORT_W-1:0]    w_grant;
  logic                 w_any;
  logic                 w_load;
  logic                 w_drain_ok;
  logic                 w_phase_done;

  // FIFO status
  always_comb begin
    w_nonempty = '0;
    w_in_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_nonempty[p] = (r_count[p] != '0);
      w_in_ready[p] = (r_count[p] <= c_ready_max);
    end
  end

  // Round-robin grant: first non-empty port at or after r_rr_ptr. Scanning
  // from the farthest offset down lets the nearest candidate win last.
  always_comb begin
    w_grant = r_rr_ptr;
    w_any   = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (w_nonempty[idx]) begin
        w_grant = PORT_W'(idx);
        w_any   = 1'b1;
      end
    end
  end

  assign w_load = ~r_out_valid | out_ready;

  // A push into a full FIFO still lands when that FIFO is popped in the same
  // cycle, since the pop frees the slot the push writes.
  always_comb begin
    w_pop  = '0;
    w_push = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_pop[p]  = w_load & w_any & (w_grant == PORT_W'(p));
      w_push[p] = in_valid[p] & ((r_count[p] != c_full) | w_pop[p]);
    end
  end

  // FIFO datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wptr[p]  <= '0;
        r_rptr[p]  <= '0;
        r_count[p] <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_push[p]) begin
          r_mem[p][r_wptr[p]] <= in_data[p*WB_WIDTH +: WB_WIDTH];
          r_wptr[p]           <= r_wptr[p] + PTR_W'(1);
        end
        if (w_pop[p]) begin
          r_rptr[p] <= r_rptr[p] + PTR_W'(1);
        end
        case ({w_push[p], w_pop[p]})
          2'b10:   r_count[p] <= r_count[p] + CNT_W'(1);
          2'b01:   r_count[p] <= r_count[p] - CNT_W'(1);
          default: r_count[p] <= r_count[p];
        endcase
        if (in_valid[p] & ~w_push[p]) begin
          r_overflow[p] <= 1'b1;
        end
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_port  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_data  <= r_mem[w_grant][r_rptr[w_grant]];
        r_out_port  <= w_grant;
        r_out_valid <= 1'b1;
        r_rr_ptr    <= (w_grant == c_last_port) ? '0 : w_grant + PORT_W'(1);
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Drained: nothing buffered and the output register is empty or being
  // accepted this cycle.
  assign w_drain_ok = ~(|w_nonempty) & (~r_out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Done tracker. COLLECT fires directly when the last ref_done lands on an
  // already drained arbiter, otherwise it waits in DRAIN.
  always_comb begin
    w_state_next = r_state;
    w_phase_done = 1'b0;
    case (r_state)
      COLLECT: begin
        if (&r_done_lat) begin
          if (w_drain_ok) begin
            w_phase_done = 1'b1;
          end else begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_drain_ok) begin
          w_phase_done = 1'b1;
          w_state_next = COLLECT;
        end
      end
      default: begin
        w_state_next = COLLECT;
      end
    endcase
  end

  // A ref_done coinciding with the clearing edge is intentionally lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_lat <= '0;
    end else if (w_phase_done) begin
      r_done_lat <= '0;
    end else begin
      r_done_lat <= r_done_lat | in_ref_done;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_data   = r_out_data;
  assign out_port   = r_out_port;
  assign out_valid  = r_out_valid;
  assign phase_done = w_phase_done;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_force_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_force_wb_arbiter
// Description : Self-checking bench for force_wb_arbiter. A queue-based
//               reference model tracks every FIFO, the output register, the
//               round-robin pointer and the done latches; DUT outputs are
//               compared against it every cycle, plus directed scenarios.
// Revision    : 1.0  initial release
// ============================================================================
module tb_force_wb_arbiter;

  localparam int NUM_PORTS  = 4;
  localparam int WB_WIDTH   = 112;
  localparam int FIFO_DEPTH = 8;
  localparam int SKID       = 2;
  localparam int PORT_W     = 2;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_PORTS*WB_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]          in_valid;
  logic [NUM_PORTS-1:0]          in_ready;
  logic [NUM_PORTS-1:0]          in_ref_done;
  logic [WB_WIDTH-1:0]           out_data;
  logic [PORT_W-1:0]             out_port;
  logic                          out_valid;
  logic                          out_ready;
  logic                          phase_done;
  logic [NUM_PORTS-1:0]          overflow;

  force_wb_arbiter #(
    .NUM_PORTS  (NUM_PORTS),
    .WB_WIDTH   (WB_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SKID       (SKID),
    .PORT_W     (PORT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ref_done (in_ref_done),
    .out_data    (out_data),
    .out_port    (out_port),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .phase_done  (phase_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef logic [WB_WIDTH-1:0] word_q_t [$];
  word_q_t              m_q [NUM_PORTS];
  bit                   m_valid;
  logic [WB_WIDTH-1:0]  m_data;
  int                   m_port;
  int                   m_rr;
  bit [NUM_PORTS-1:0]   m_ovf;
  bit [NUM_PORTS-1:0]   m_dl;

  int checks   = 0;
  int failures = 0;

  // Observation counters updated at each sampling point
  int pd_count;
  int pd_with_accept;
  int p1_accepts;
  int valid_seen;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_pd();
    bit empty;
    empty = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) if (m_q[p].size() != 0) empty = 1'b0;
    return (&m_dl) && empty && (!m_valid || out_ready);
  endfunction

  function automatic logic [NUM_PORTS-1:0] model_ready();
    logic [NUM_PORTS-1:0] r;
    for (int p = 0; p < NUM_PORTS; p++) r[p] = (m_q[p].size() <= FIFO_DEPTH - SKID);
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic model_update();
    bit pd;
    int g;
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) m_q[p].delete();
      m_valid = 1'b0; m_data = '0; m_port = 0; m_rr = 0; m_ovf = '0; m_dl = '0;
      return;
    end
    pd = model_pd();
    if (!m_valid || out_ready) begin
      g = -1;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (g < 0 && m_q[(m_rr + k) % NUM_PORTS].size() != 0) g = (m_rr + k) % NUM_PORTS;
      end
      if (g >= 0) begin
        m_data  = m_q[g].pop_front();
        m_port  = g;
        m_valid = 1'b1;
        m_rr    = (g + 1) % NUM_PORTS;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_valid[p]) begin
        if (m_q[p].size() < FIFO_DEPTH) m_q[p].push_back(in_data[p*WB_WIDTH +: WB_WIDTH]);
        else m_ovf[p] = 1'b1;
      end
    end
    if (pd) m_dl = '0;
    else    m_dl = m_dl | in_ref_done;
  endtask

  // One cycle: compare at the falling edge, then advance DUT and model.
  task automatic tick();
    @(negedge clk);
    check_eq("out_valid",  out_valid,  m_valid);
    check_eq("out_data",   out_data,   m_data);
    check_eq("out_port",   out_port,   m_port);
    check_eq("in_ready",   in_ready,   model_ready());
    check_eq("overflow",   overflow,   m_ovf);
    check_eq("phase_done", phase_done, model_pd());
    if (phase_done === 1'b1) begin
      pd_count++;
      if (out_valid === 1'b0 || out_ready === 1'b1) pd_with_accept++;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1 && out_port === 2'd1) p1_accepts++;
    if (out_valid === 1'b1) valid_seen++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [WB_WIDTH-1:0] rword();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[WB_WIDTH-1:0];
  endfunction

  task automatic idle_inputs();
    in_valid = '0; in_ref_done = '0;
    for (int p = 0; p < NUM_PORTS; p++) in_data[p*WB_WIDTH +: WB_WIDTH] = rword();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [WB_WIDTH-1:0] w;
    bit pending3;
    int streak, max_streak, p3_grants;

    rst = 1'b1; out_ready = 1'b0; in_data = '0; in_valid = '0; in_ref_done = '0;
    @(posedge clk); model_update(); #1;
    // Reset state is compared by the first tick
    tick();
    check_eq("rst_in_ready", in_ready, 4'hF);
    rst = 1'b0;

    // 1: single word on port 2
    out_ready = 1'b1;
    w = rword(); w[7:0] = 8'hA5;
    in_data[2*WB_WIDTH +: WB_WIDTH] = w;
    in_valid = 4'b0100;
    tick();
    idle_inputs();
    check_eq("t1_lat1_valid", out_valid, 1'b0);
    tick();
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_port", out_port, 2);
    check_eq("t1_data", out_data[7:0], 8'hA5);
    check_eq("t1_ready", in_ready, 4'hF);
    repeat (3) tick();

    // 2: simultaneous burst on all ports, twice, from rr_ptr = 0
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < NUM_PORTS; p++) in_data[p*WB_WIDTH +: WB_WIDTH] = rword();
      in_valid = 4'hF;
      tick();
      idle_inputs();
      for (int i = 0; i < NUM_PORTS; i++) begin
        tick();
        check_eq($sformatf("t2_order_b%0d_%0d", b, i), out_port, i);
      end
    end
    repeat (2) tick();

    // 3: fill port 1 behind a stalled output register
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0001;
    tick();
    idle_inputs();
    tick();
    for (int i = 1; i <= 9; i++) begin
      in_data[1*WB_WIDTH +: WB_WIDTH] = rword();
      in_valid = 4'b0010;
      tick();
      if (i == 6) check_eq("t3_ready_at6", in_ready[1], 1'b1);
      if (i == 7) check_eq("t3_ready_at7", in_ready[1], 1'b0);
      if (i == 8) check_eq("t3_ovf_at8", overflow[1], 1'b0);
      if (i == 9) check_eq("t3_ovf_at9", overflow[1], 1'b1);
    end
    idle_inputs();
    p1_accepts = 0;
    out_ready = 1'b1;
    repeat (14) tick();
    check_eq("t3_p1_count", p1_accepts, 8);

    // 4: port 0 continuous, port 3 sporadic
    do_reset();
    out_ready = 1'b1;
    streak = 0; max_streak = 0; p3_grants = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int p = 0; p < NUM_PORTS; p++) in_data[p*WB_WIDTH +: WB_WIDTH] = rword();
      in_valid = {($urandom_range(0, 7) == 0), 2'b00, 1'b1};
      pending3 = (m_q[3].size() != 0);
      tick();
      if (pending3) begin
        if (out_valid === 1'b1 && out_port === 2'd3) begin
          streak = 0; p3_grants++;
        end else begin
          streak++;
          if (streak > max_streak) max_streak = streak;
        end
      end
    end
    idle_inputs();
    check_eq("t4_max_wait_le1", (max_streak <= 1), 1'b1);
    check_eq("t4_p3_served", (p3_grants > 0), 1'b1);
    repeat (12) tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        in_data[p*WB_WIDTH +: WB_WIDTH] = rword();
        in_valid[p] = ($urandom_range(0, 2) == 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (40) tick();

    // 5: phase_done after staggered ref_done with 3 words buffered
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) in_data[p*WB_WIDTH +: WB_WIDTH] = rword();
    in_valid = 4'b0111;
    tick();
    idle_inputs();
    pd_count = 0; pd_with_accept = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_ref_done = 4'(1 << p);
      tick();
      in_ref_done = '0;
      tick();
    end
    check_eq("t5_no_early_pd", pd_count, 0);
    out_ready = 1'b1;
    repeat (12) tick();
    check_eq("t5_pd_once", pd_count, 1);
    check_eq("t5_pd_on_accept", pd_with_accept, 1);

    // 6: reset with words buffered and output valid
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) in_data[p*WB_WIDTH +: WB_WIDTH] = rword();
    in_valid = 4'hF;
    tick();
    in_valid = 4'b0010;
    in_data[1*WB_WIDTH +: WB_WIDTH] = rword();
    tick();
    idle_inputs();
    tick();
    check_eq("t6_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_valid", out_valid, 1'b0);
    check_eq("t6_ready", in_ready, 4'hF);
    check_eq("t6_ovf", overflow, 4'h0);
    out_ready = 1'b1;
    valid_seen = 0;
    repeat (10) tick();
    check_eq("t6_no_stale", valid_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
